pipe_ctrl: RTL

Central hazard and sequencing controller for the RV32I 5-stage pipeline: F (fetch), D, A, M and W stage registers. It generates per-stage STALL/FLUSH strobes for the stage registers from four sources: jump redirects out of the M register, load-use hazards between the D and A registers, instruction-fetch wait, and data-memory bus handshakes. It owns the data-bus request/ack sequencing and its timeout, and keeps a stall-cycle performance counter.

---
 rtl/pipe_ctrl_if.sv | 44 ++++
 rtl/pipe_ctrl.sv | 99 +++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline-side view of the hazard controller: stage status in, stage strobes out,
// plus the data-bus request/ack pair and the status/performance outputs.
interface pipe_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic             I_WAIT;
   logic             D_VALID;
   logic [4:0]       D_RS1;
   logic [4:0]       D_RS2;
   logic             D_USE_RS1;
   logic             D_USE_RS2;
   logic             A_VALID;
   logic             A_LOAD;
   logic [4:0]       A_REG_D;
   logic             M_VALID;
   logic             M_MEM;
   logic             DO_JMP;
   logic             BUS_ACK;
   logic             BUS_REQ;
   logic             STALL_F;
   logic             STALL_D;
   logic             STALL_A;
   logic             STALL_M;
   logic             STALL_W;
   logic             FLUSH_D;
   logic             FLUSH_A;
   logic             FLUSH_M;
   logic             BUS_ERR;
   logic [CNT_W-1:0] STALL_CNT;

   // master: the controller; slave: the datapath / bus side
   modport master (
      input  I_WAIT, D_VALID, D_RS1, D_RS2, D_USE_RS1, D_USE_RS2,
             A_VALID, A_LOAD, A_REG_D, M_VALID, M_MEM, DO_JMP, BUS_ACK,
      output BUS_REQ, STALL_F, STALL_D, STALL_A, STALL_M, STALL_W,
             FLUSH_D, FLUSH_A, FLUSH_M, BUS_ERR, STALL_CNT
   );
   modport slave (
      output I_WAIT, D_VALID, D_RS1, D_RS2, D_USE_RS1, D_USE_RS2,
             A_VALID, A_LOAD, A_REG_D, M_VALID, M_MEM, DO_JMP, BUS_ACK,
      input  BUS_REQ, STALL_F, STALL_D, STALL_A, STALL_M, STALL_W,
             FLUSH_D, FLUSH_A, FLUSH_M, BUS_ERR, STALL_CNT
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: stall/flush
// strobes, data-bus request/ack sequencing with timeout, and a stall counter.
module pipe_ctrl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 32
) (
   input  logic        CLK,
   input  logic        RST,
   pipe_ctrl_if.master bus
);
   typedef enum logic {IDLE, WAIT} state_t;

   localparam logic [15:0] TO = 16'(TIMEOUT);

   state_t           state;
   logic [15:0]      wcnt;
   logic             bus_err;
   logic [CNT_W-1:0] stall_cnt;

   logic mreq, at_to, memstall, load_use, bus_req;
   logic [4:0] stall;   // {F, D, A, M, W}
   logic [2:0] flush;   // {D, A, M}

   always_comb begin
      mreq     = bus.M_VALID & bus.M_MEM;
      at_to    = (wcnt == TO);
      memstall = (state == IDLE) ? (mreq & ~bus.BUS_ACK)
                                 : (~bus.BUS_ACK & ~at_to);
      load_use = bus.D_VALID & bus.A_VALID & bus.A_LOAD & (bus.A_REG_D != 5'd0) &
                 ((bus.D_USE_RS1 & (bus.D_RS1 == bus.A_REG_D)) |
                  (bus.D_USE_RS2 & (bus.D_RS2 == bus.A_REG_D)));
      bus_req  = 1'b0;
      stall    = '0;
      flush    = '0;
      if (!RST) begin
         bus_req = (state == WAIT) | mreq;
         if (memstall)
            stall = '1;
         else if (bus.DO_JMP)
            flush = '1;
         else if (load_use) begin
            stall = 5'b11000;
            flush = 3'b010;
         end else if (bus.I_WAIT) begin
            stall = 5'b10000;
            flush = 3'b100;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         wcnt      <= '0;
         bus_err   <= 1'b0;
         stall_cnt <= '0;
      end else begin
         if (stall[4])
            stall_cnt <= stall_cnt + 1'b1;
         case (state)
            IDLE: begin
               if (mreq && !bus.BUS_ACK) begin
                  state <= WAIT;
                  wcnt  <= 16'd1;
               end
            end
            WAIT: begin
               if (bus.BUS_ACK) begin
                  state <= IDLE;
                  wcnt  <= '0;
               end else if (at_to) begin
                  // abort: the M instruction retires without data
                  bus_err <= 1'b1;
                  state   <= IDLE;
                  wcnt    <= '0;
               end else begin
                  wcnt <= wcnt + 16'd1;
               end
            end
            default: begin
               state <= IDLE;
               wcnt  <= '0;
            end
         endcase
      end
   end

   assign bus.BUS_REQ   = bus_req;
   assign bus.STALL_F   = stall[4];
   assign bus.STALL_D   = stall[3];
   assign bus.STALL_A   = stall[2];
   assign bus.STALL_M   = stall[1];
   assign bus.STALL_W   = stall[0];
   assign bus.FLUSH_D   = flush[2];
   assign bus.FLUSH_A   = flush[1];
   assign bus.FLUSH_M   = flush[0];
   assign bus.BUS_ERR   = bus_err;
   assign bus.STALL_CNT = stall_cnt;
endmodule
